// File: rtl/niosballe_pio_gen_if.sv
// niosballe_pio_gen_if
// Avalon-MM slave bus for the parallel I/O peripheral.
//   address    : register word index (master -> slave)
//   chipselect : slave select (master -> slave)
//   write_n    : active-low write strobe (master -> slave)
//   writedata  : write data (master -> slave)
//   readdata   : read data, combinational from address (slave -> master)
//
// Handshake: the slave has no wait states and no waitrequest. A write is
// accepted on every rising clk edge where chipselect=1 and write_n=0.
// readdata is valid in the same cycle address is presented, and reads have
// no side effects, so no read strobe is carried.
interface niosballe_pio_gen_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosballe_pio_gen.sv
// niosballe_pio_gen
// Avalon-MM parallel I/O with per-bit direction, atomic set/clear of the
// output register, synchronised inputs, per-bit edge capture and a maskable
// level interrupt.
//
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   bus         : Avalon-MM slave (see niosballe_pio_gen_if)
//   in_port     : asynchronous pin inputs
//   out_port    : output data register
//   out_en      : per-bit output enable (direction register, 1 = output)
//   irq         : level interrupt, active-high
//   prime_state : debug view of the prime FSM (0 = PRIMING, 1 = ARMED)
//
// Register map (word index): 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP (W1C),
// 4 OUTSET, 5 OUTCLR, 6/7 reserved.
module niosballe_pio_gen #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  niosballe_pio_gen_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     out_en,
  output logic                 irq,
  output logic                 prime_state
);

  typedef enum logic {
    PRIMING = 1'b0,
    ARMED   = 1'b1
  } prime_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wd;
  logic             wr_en;
  logic             armed;
  logic             unused_wd;
  prime_e           state_q;
  prime_e           state_d;
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  // Upper write data bits are deliberately ignored.
  assign unused_wd = &{1'b0, bus.writedata};
  assign sync_last = sync_q[SYNC_STAGES-1];

  // Input synchroniser plus the previous-value register used for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last;
    end
  end

  // Prime FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRIMING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prime FSM: next state. The edge that moves to ARMED is the
  // (SYNC_STAGES+1)th after release; by then prev holds the settled pin value,
  // so pins already high at reset never look like a fresh edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PRIMING: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(SYNC_STAGES)) state_d = ARMED;
      end
      default: ;
    endcase
  end

  // Prime FSM: outputs.
  always_comb begin
    armed       = (state_q == ARMED);
    prime_state = state_q;
  end

  // Edge selection; independent of direction.
  always_comb begin
    rise = sync_last & ~prev_q;
    fall = ~sync_last & prev_q;
    if (EDGE_TYPE == 0)      det = rise;
    else if (EDGE_TYPE == 1) det = fall;
    else                     det = rise | fall;
  end

  // Clear is applied first, then new edges are OR-ed in, so an edge arriving
  // in the same cycle as a write-1-clear keeps the bit set.
  always_comb begin
    cap_clr    = (wr_en && bus.address == 3'd3) ? wd : '0;
    edge_cap_d = (edge_cap_q & ~cap_clr) | (armed ? det : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT[WIDTH-1:0];
      dir_q      <= RESET_DIR[WIDTH-1:0];
      mask_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      if (wr_en) begin
        case (bus.address)
          3'd0:    data_out_q <= wd;
          3'd1:    dir_q      <= wd;
          3'd2:    mask_q     <= wd;
          3'd4:    data_out_q <= data_out_q | wd;
          3'd5:    data_out_q <= data_out_q & ~wd;
          default: ;
        endcase
      end
      edge_cap_q <= edge_cap_d;
    end
  end

  // Zero-latency read mux; unused upper bits read as 0.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0:    bus.readdata = 32'((data_out_q & dir_q) | (sync_last & ~dir_q));
      3'd1:    bus.readdata = 32'(dir_q);
      3'd2:    bus.readdata = 32'(mask_q);
      3'd3:    bus.readdata = 32'(edge_cap_q);
      default: bus.readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign out_en   = dir_q;
  assign irq      = |(edge_cap_q & mask_q);

endmodule
